// File: rtl/kbd_scan.sv
// -----------------------------------------------------------------------------
// kbd_scan : 4x4 matrix keypad scanner with press/release debounce.
//
// Columns are driven active-low one at a time.  When exactly one row reads low
// the column is frozen and the row pattern must stay stable for
// DEBOUNCE_CYCLES cycles before the key is accepted.  Acceptance produces a
// one-cycle num (digit) or op (non-digit) pulse and updates key_code.  The key
// must then read fully released for DEBOUNCE_CYCLES cycles before scanning
// resumes, so a second key pressed in the meantime is ignored.
//
// Optional feature macro: KBD_AUTOREPEAT_EN
//   When defined, a held key re-pulses num/op every REPEAT_CYCLES cycles.
//
// Parameters
//   SCAN_DIV        cycles each column is driven while scanning
//   DEBOUNCE_CYCLES stable cycles required for press and for release
//   REPEAT_CYCLES   auto-repeat period (KBD_AUTOREPEAT_EN only)
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   row_in    in   [3:0] keypad rows, active-low, asynchronous to clk
//   col_out   out  [3:0] keypad columns, active-low one-cold
//   num       out  one-cycle pulse, digit key 0-9 accepted
//   op        out  one-cycle pulse, non-digit key accepted
//   key_code  out  [3:0] code of last accepted key
// -----------------------------------------------------------------------------
module kbd_scan #(
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_CYCLES = 20000,
   parameter int REPEAT_CYCLES   = 5000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   output logic       num,
   output logic       op,
   output logic [3:0] key_code
);

   // One shared width covers both the scan divider and the debounce counter.
   localparam int CNT_MAX = (DEBOUNCE_CYCLES > SCAN_DIV) ? DEBOUNCE_CYCLES : SCAN_DIV;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

`ifdef KBD_AUTOREPEAT_EN
   localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
   localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);
   localparam logic [REP_W-1:0] REP_ZERO = REP_W'(0);
`endif

   typedef enum logic [1:0] {
      SCAN      = 2'd0,
      DEB_PRESS = 2'd1,
      HELD      = 2'd2,
      DEB_REL   = 2'd3
   } state_t;

   // True when exactly one row is pulled low.
   function automatic logic one_low(input logic [3:0] rows);
      logic hit;
      case (rows)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: hit = 1'b1;
         default:                            hit = 1'b0;
      endcase
      return hit;
   endfunction

   // Index of the single low bit in a one-cold vector.
   function automatic logic [1:0] cold_idx(input logic [3:0] v);
      logic [1:0] idx;
      case (v)
         4'b1110: idx = 2'd0;
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   // Keypad legend: {row, col} -> key code (* = 0xE, # = 0xF).
   function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] code;
      case ({r, c})
         4'h0: code = 4'h1;
         4'h1: code = 4'h2;
         4'h2: code = 4'h3;
         4'h3: code = 4'hA;
         4'h4: code = 4'h4;
         4'h5: code = 4'h5;
         4'h6: code = 4'h6;
         4'h7: code = 4'hB;
         4'h8: code = 4'h7;
         4'h9: code = 4'h8;
         4'hA: code = 4'h9;
         4'hB: code = 4'hC;
         4'hC: code = 4'hE;
         4'hD: code = 4'h0;
         4'hE: code = 4'hF;
         4'hF: code = 4'hD;
         default: code = 4'h0;
      endcase
      return code;
   endfunction

   logic [3:0]       row_meta_r;
   logic [3:0]       rows_s;
   state_t           state_r,    state_s;
   logic [3:0]       col_r,      col_s;
   logic [CNT_W-1:0] scan_cnt_r, scan_cnt_s;
   logic [CNT_W-1:0] deb_cnt_r,  deb_cnt_s;
   logic [3:0]       row_lat_r,  row_lat_s;
   logic [3:0]       key_code_r, key_code_s;
   logic             num_r,      num_s;
   logic             op_r,       op_s;
   logic             fire_s;
   logic [3:0]       code_s;
`ifdef KBD_AUTOREPEAT_EN
   logic [REP_W-1:0] rep_cnt_r,  rep_cnt_s;
`endif

   // Two-flop row synchronizer; idle level is all rows high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_meta_r <= 4'b1111;
         rows_s     <= 4'b1111;
      end else begin
         row_meta_r <= row_in;
         rows_s     <= row_meta_r;
      end
   end

   // Next-state, counter and output decode for the scan/debounce FSM.
   always_comb begin
      state_s    = state_r;
      col_s      = col_r;
      scan_cnt_s = scan_cnt_r;
      deb_cnt_s  = deb_cnt_r;
      row_lat_s  = row_lat_r;
      key_code_s = key_code_r;
      fire_s     = 1'b0;
      code_s     = key_lookup(cold_idx(row_lat_r), cold_idx(col_r));
`ifdef KBD_AUTOREPEAT_EN
      rep_cnt_s  = REP_ZERO;
`endif

      case (state_r)
         SCAN: begin
            if (one_low(rows_s)) begin
               state_s    = DEB_PRESS;
               row_lat_s  = rows_s;
               deb_cnt_s  = CNT_ZERO;
               scan_cnt_s = CNT_ZERO;
            end else if (scan_cnt_r == SCAN_LAST) begin
               col_s      = {col_r[2:0], col_r[3]};
               scan_cnt_s = CNT_ZERO;
            end else begin
               scan_cnt_s = scan_cnt_r + CNT_ONE;
            end
         end

         DEB_PRESS: begin
            if (rows_s != row_lat_r) begin
               // Bounce: resume scanning from the frozen column.
               state_s   = SCAN;
               deb_cnt_s = CNT_ZERO;
            end else if (deb_cnt_r == DEB_LAST) begin
               state_s    = HELD;
               deb_cnt_s  = CNT_ZERO;
               key_code_s = code_s;
               fire_s     = 1'b1;
            end else begin
               deb_cnt_s = deb_cnt_r + CNT_ONE;
            end
         end

         HELD: begin
            if (rows_s == 4'b1111) begin
               state_s   = DEB_REL;
               deb_cnt_s = CNT_ZERO;
            end else begin
`ifdef KBD_AUTOREPEAT_EN
               if (rep_cnt_r == REP_LAST) begin
                  fire_s    = 1'b1;
                  rep_cnt_s = REP_ZERO;
               end else begin
                  rep_cnt_s = rep_cnt_r + REP_ONE;
               end
`else
               state_s = HELD;
`endif
            end
         end

         DEB_REL: begin
            if (rows_s != 4'b1111) begin
               state_s   = HELD;
               deb_cnt_s = CNT_ZERO;
            end else if (deb_cnt_r == DEB_LAST) begin
               state_s    = SCAN;
               deb_cnt_s  = CNT_ZERO;
               scan_cnt_s = CNT_ZERO;
            end else begin
               deb_cnt_s = deb_cnt_r + CNT_ONE;
            end
         end

         default: begin
            state_s    = SCAN;
            col_s      = 4'b1110;
            scan_cnt_s = CNT_ZERO;
            deb_cnt_s  = CNT_ZERO;
         end
      endcase

      // Codes 0x0-0x9 are digits, everything above is an operator key.
      num_s = fire_s & (code_s <= 4'h9);
      op_s  = fire_s & (code_s >  4'h9);
   end

   // FSM state, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= SCAN;
         col_r      <= 4'b1110;
         scan_cnt_r <= CNT_ZERO;
         deb_cnt_r  <= CNT_ZERO;
         row_lat_r  <= 4'b1111;
         key_code_r <= 4'h0;
         num_r      <= 1'b0;
         op_r       <= 1'b0;
`ifdef KBD_AUTOREPEAT_EN
         rep_cnt_r  <= REP_ZERO;
`endif
      end else begin
         state_r    <= state_s;
         col_r      <= col_s;
         scan_cnt_r <= scan_cnt_s;
         deb_cnt_r  <= deb_cnt_s;
         row_lat_r  <= row_lat_s;
         key_code_r <= key_code_s;
         num_r      <= num_s;
         op_r       <= op_s;
`ifdef KBD_AUTOREPEAT_EN
         rep_cnt_r  <= rep_cnt_s;
`endif
      end
   end

   assign col_out  = col_r;
   assign num      = num_r;
   assign op       = op_r;
   assign key_code = key_code_r;

endmodule

// File: tb/tb_kbd_scan.sv
// -----------------------------------------------------------------------------
// tb_kbd_scan : scoreboard bench for kbd_scan (SCAN_DIV=4, DEBOUNCE_CYCLES=8,
// REPEAT_CYCLES=32).  A keypad model closes the matrix through col_out; every
// press pushes its expected pulse(s) into a queue, and an independent monitor
// pops and compares whenever num or op is seen.
// -----------------------------------------------------------------------------
module tb_kbd_scan;

   typedef struct packed {
      logic       is_num;
      logic [3:0] code;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] row_in;
   logic [3:0] col_out;
   logic       num;
   logic       op;
   logic [3:0] key_code;

   logic       key_on = 1'b0;
   logic [1:0] key_r  = 2'd0;
   logic [1:0] key_c  = 2'd0;
   logic [3:0] direct_rows = 4'b1111;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   kbd_scan #(
      .SCAN_DIV(4),
      .DEBOUNCE_CYCLES(8),
      .REPEAT_CYCLES(32)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .row_in(row_in),
      .col_out(col_out),
      .num(num),
      .op(op),
      .key_code(key_code)
   );

   // Keypad matrix: a pressed key pulls its row low only while its column is driven.
   always_comb begin
      row_in = direct_rows;
      if (key_on && (col_out[key_c] == 1'b0)) begin
         row_in[key_r] = 1'b0;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic push_exp(input logic [3:0] code);
      exp_t e;
      e.is_num = (code <= 4'h9);
      e.code   = code;
      exp_q.push_back(e);
   endtask

   task automatic wait_col(input string name, input logic [3:0] val, input int budget);
      int n = 0;
      while (col_out !== val && n < budget) begin
         tick(1);
         n++;
      end
      if (col_out !== val) begin
         checks++;
         errors++;
         $display("FAIL %s timeout col_out=%b required=%b", name, col_out, val);
      end
   endtask

   task automatic wait_pulse(input string name, input int budget, output int lat);
      lat = 0;
      while (!(num || op) && lat < budget) begin
         tick(1);
         lat++;
      end
      if (!(num || op)) begin
         checks++;
         errors++;
         $display("FAIL %s timeout no pulse after %0d cycles required pulse", name, budget);
      end
   endtask

   task automatic check_rotating(input string name);
      int         changes = 0;
      logic [3:0] prev;
      prev = col_out;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (col_out !== prev) changes++;
         prev = col_out;
      end
      chk(name, changes, 5);
   endtask

   // Scoreboard monitor: pops one expectation per observed pulse.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && num === 1'b1 && op === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL both_pulses num=%b op=%b required one of them", num, op);
         end else if (rst_n === 1'b1 && (num === 1'b1 || op === 1'b1)) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_pulse num=%b op=%b key_code=%h required no pulse",
                        num, op, key_code);
            end else begin
               e = exp_q.pop_front();
               if (num !== e.is_num || op !== ~e.is_num || key_code !== e.code) begin
                  errors++;
                  $display("FAIL pulse num=%b op=%b key_code=%h required num=%b key_code=%h",
                           num, op, key_code, e.is_num, e.code);
               end
            end
         end
      end
   end

   // Watchdog.
   initial begin
      #1000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] tbl_r    [6] = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd2, 2'd0};
      logic [1:0] tbl_c    [6] = '{2'd3, 2'd1, 2'd0, 2'd2, 2'd2, 2'd3};
      logic [3:0] tbl_code [6] = '{4'hD, 4'h0, 4'hE, 4'hF, 4'h9, 4'hA};
      int lat;

      // Reset values.
      rst_n = 1'b0;
      tick(3);
      chk("rst_col_out", col_out, 4'b1110);
      chk("rst_num", num, 1'b0);
      chk("rst_op", op, 1'b0);
      chk("rst_key_code", key_code, 4'h0);
      rst_n = 1'b1;
      tick(2);
      chk("post_rst_col", col_out, 4'b1110);

      // Key 5 held, with exact latency and column-freeze checks.
      wait_col("k5_col0", 4'b1110, 40);
      key_r = 2'd1; key_c = 2'd1; key_on = 1'b1;
      push_exp(4'h5);
      wait_col("k5_col1", 4'b1101, 40);
      wait_pulse("k5_pulse", 60, lat);
      chk("k5_latency", lat, 11);
      chk("k5_key_code", key_code, 4'h5);
      chk("k5_col_at_accept", col_out, 4'b1101);
      tick(29);
      chk("k5_col_held", col_out, 4'b1101);
      key_on = 1'b0;
      tick(13);
      chk("k5_col_rel_deb", col_out, 4'b1101);
      tick(3);
      chk("k5_col_resume", col_out, 4'b1011);
      chk("k5_key_code_kept", key_code, 4'h5);
      tick(20);

      // Directed key table (D, 0, *, #, 9, A).
      for (int i = 0; i < 6; i++) begin
         key_r = tbl_r[i]; key_c = tbl_c[i]; key_on = 1'b1;
         push_exp(tbl_code[i]);
         wait_pulse("tbl_pulse", 80, lat);
         tick(1);
         chk("tbl_key_code", key_code, tbl_code[i]);
         key_on = 1'b0;
         tick(30);
      end

      // Row0 bounce on column 0: no pulse, scanning resumes.
      wait_col("bounce_col3", 4'b0111, 40);
      wait_col("bounce_col0", 4'b1110, 40);
      direct_rows = 4'b1110; tick(3);
      direct_rows = 4'b1111; tick(1);
      direct_rows = 4'b1110; tick(3);
      direct_rows = 4'b1111; tick(10);
      check_rotating("bounce_scan_resumes");

      // Rows 0 and 2 low together: ignored, columns keep rotating.
      direct_rows = 4'b1010;
      check_rotating("multi_row_rotates");
      direct_rows = 4'b1111;
      tick(10);

      // Reset during debounce of key 7.
      wait_col("k7_col3", 4'b0111, 40);
      key_r = 2'd2; key_c = 2'd0; key_on = 1'b1;
      wait_col("k7_col0", 4'b1110, 40);
      tick(5);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_key_code", key_code, 4'h0);
      chk("mid_rst_num", num, 1'b0);
      chk("mid_rst_op", op, 1'b0);
      key_on = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(40);

      // Key 2 held 100 cycles past accept.
      key_r = 2'd0; key_c = 2'd1; key_on = 1'b1;
      push_exp(4'h2);
`ifdef KBD_AUTOREPEAT_EN
      push_exp(4'h2);
      push_exp(4'h2);
      push_exp(4'h2);
`endif
      wait_pulse("k2_pulse", 80, lat);
      tick(100);
      chk("k2_key_code", key_code, 4'h2);
      key_on = 1'b0;
      tick(40);
      chk("pending_pulses", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
